// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, frame state encoding and a frame-length helper.
// Used by the transmitter core and by the planned receiver.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // Clock cycles occupied by one complete character frame on the line.
  function automatic int unsigned frame_cycles(
    input int unsigned clks_per_bit,
    input int unsigned data_bits,
    input int unsigned parity,
    input int unsigned stop_bits
  );
    int unsigned par_bits;
    par_bits = (parity != PAR_NONE) ? 1 : 0;
    return (1 + data_bits + par_bits + stop_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last and next-to-last
// cycle of each bit. Held at zero while i_clear is high.
module uart_baud_counter #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  output logic o_bit_end_c,
  output logic o_pre_end_c
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             w_bit_end;
  logic             w_pre_end;

  assign w_bit_end = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign w_pre_end = (r_cnt == CNT_W'(CLKS_PER_BIT - 2));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clear || w_bit_end) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_bit_end_c = w_bit_end;
  assign o_pre_end_c = w_pre_end;

endmodule

// File: rtl/uart_tx_core.sv
// Parametrised UART transmitter: start bit, 5..9 data bits LSB first, optional
// parity and 1 or 2 stop bits, one character per valid/ready handshake.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned BAUD        = 115_200,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY      = 0,
  parameter int unsigned STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_serial,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int unsigned CLKS_PER_BIT = (BAUD == 0) ? 2 : (CLK_FREQ_HZ / BAUD);
  localparam int unsigned BIT_W        = 4;

  if ((BAUD == 0) || (CLK_FREQ_HZ < 2 * BAUD)) begin : g_bad_baud
    $error("uart_tx_core: CLK_FREQ_HZ / BAUD must be at least 2");
  end
  if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data_bits
    $error("uart_tx_core: DATA_BITS must be in 5..9");
  end
  if (PARITY > PAR_EVEN) begin : g_bad_parity
    $error("uart_tx_core: PARITY must be 0 (none), 1 (odd) or 2 (even)");
  end
  if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop_bits
    $error("uart_tx_core: STOP_BITS must be 1 or 2");
  end

  tx_state_e            r_state;
  tx_state_e            w_state_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_parity;
  logic [BIT_W-1:0]     r_bit_idx;
  logic                 r_serial;
  logic                 r_ready;
  logic                 r_busy;
  logic                 r_done;

  logic w_hs;
  logic w_clear;
  logic w_bit_end_c;
  logic w_pre_end_c;
  logic w_last_data;
  logic w_last_stop;
  logic w_advance;
  logic w_serial_nxt;
  logic w_ready_nxt;
  logic w_busy_nxt;
  logic w_done_nxt;

  assign w_hs        = tx_valid & r_ready;
  assign w_clear     = (r_state == ST_IDLE);
  assign w_last_data = (r_bit_idx == BIT_W'(DATA_BITS - 1));
  assign w_last_stop = (r_bit_idx == BIT_W'(STOP_BITS - 1));

  uart_baud_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_clear     (w_clear),
    .o_bit_end_c (w_bit_end_c),
    .o_pre_end_c (w_pre_end_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The final stop bit hands back to IDLE one cycle early so that its last cycle
  // is the tx_done/tx_ready cycle; a waiting producer then starts with no gap.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_hs) begin
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (w_bit_end_c) begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_bit_end_c && w_last_data) begin
          w_state_nxt = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (w_bit_end_c) begin
          w_state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_pre_end_c && w_last_stop) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; the line only moves on bit boundaries.
  always_comb begin
    w_serial_nxt = r_serial;
    w_advance    = (w_state_nxt != r_state) || ((r_state == ST_DATA) && w_bit_end_c);
    if (w_advance) begin
      case (w_state_nxt)
        ST_IDLE:   w_serial_nxt = 1'b1;
        ST_START:  w_serial_nxt = 1'b0;
        ST_DATA:   w_serial_nxt = (r_state == ST_DATA) ? r_shift[1] : r_shift[0];
        ST_PARITY: w_serial_nxt = r_parity;
        ST_STOP:   w_serial_nxt = 1'b1;
        default:   w_serial_nxt = 1'b1;
      endcase
    end
    w_ready_nxt = (w_state_nxt == ST_IDLE);
    w_busy_nxt  = (w_state_nxt != ST_IDLE);
    w_done_nxt  = (r_state == ST_STOP) && (w_state_nxt == ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_serial <= 1'b1;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_serial <= w_serial_nxt;
      r_ready  <= w_ready_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  // Character is captured only on the handshake; later tx_data changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_bit_idx <= '0;
    end else begin
      if (w_hs) begin
        r_shift  <= tx_data;
        r_parity <= (PARITY == PAR_EVEN) ? (^tx_data) : ~(^tx_data);
      end else if ((r_state == ST_DATA) && w_bit_end_c) begin
        r_shift <= r_shift >> 1;
      end
      if (w_state_nxt != r_state) begin
        r_bit_idx <= '0;
      end else if (w_bit_end_c && ((r_state == ST_DATA) || (r_state == ST_STOP))) begin
        r_bit_idx <= r_bit_idx + BIT_W'(1);
      end
    end
  end

  assign tx_serial = r_serial;
  assign tx_ready  = r_ready;
  assign tx_busy   = r_busy;
  assign tx_done   = r_done;

endmodule

// File: tb/tb_uart_tx_core.sv
// Self-checking bench for uart_tx_core: four instances (8N1, 8E1, 8O1, 7N2) at
// 10 clocks per bit, compared against a per-cycle frame model built from the bit list.
module tb_uart_tx_core;

  localparam int unsigned CLK_HZ = 50_000_000;
  localparam int unsigned BAUD   = 5_000_000;
  localparam int          CPB    = CLK_HZ / BAUD;

  localparam int DB  [4] = '{8, 8, 8, 7};
  localparam int PAR [4] = '{0, 2, 1, 0};
  localparam int SB  [4] = '{1, 1, 1, 2};

  logic       clk;
  logic       rst;
  logic [8:0] tx_data_a [4];
  logic [3:0] valid_r;
  wire  [3:0] ser_w;
  wire  [3:0] rdy_w;
  wire  [3:0] busy_w;
  wire  [3:0] done_w;

  int n_tests;
  int n_fail;

  uart_tx_core #(.CLK_FREQ_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .tx_data(tx_data_a[0][7:0]), .tx_valid(valid_r[0]),
    .tx_ready(rdy_w[0]), .tx_serial(ser_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));
  uart_tx_core #(.CLK_FREQ_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst(rst), .tx_data(tx_data_a[1][7:0]), .tx_valid(valid_r[1]),
    .tx_ready(rdy_w[1]), .tx_serial(ser_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]));
  uart_tx_core #(.CLK_FREQ_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst(rst), .tx_data(tx_data_a[2][7:0]), .tx_valid(valid_r[2]),
    .tx_ready(rdy_w[2]), .tx_serial(ser_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]));
  uart_tx_core #(.CLK_FREQ_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
    .clk(clk), .rst(rst), .tx_data(tx_data_a[3][6:0]), .tx_valid(valid_r[3]),
    .tx_ready(rdy_w[3]), .tx_serial(ser_w[3]), .tx_busy(busy_w[3]), .tx_done(done_w[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int flen(input int idx);
    return (1 + DB[idx] + ((PAR[idx] != 0) ? 1 : 0) + SB[idx]) * CPB;
  endfunction

  // Expected line level for cycles 1..256 after the first handshake (bit k = cycle k+1).
  function automatic logic [255:0] exp_line(input int idx, input logic [8:0] d0,
                                            input logic [8:0] d1, input int nfr);
    logic [255:0] v;
    logic [8:0]   d;
    int           q[$];
    int           ones;
    int           p;
    v = '1;
    for (int f = 0; f < nfr; f++) begin
      d = (f == 0) ? d0 : d1;
      q.push_back(0);
      ones = 0;
      for (int i = 0; i < DB[idx]; i++) begin
        q.push_back(int'(d[i]));
        ones += int'(d[i]);
      end
      if (PAR[idx] != 0) begin
        p = ones % 2;
        if (PAR[idx] == 1) p = 1 - p;
        q.push_back(p);
      end
      for (int s = 0; s < SB[idx]; s++) q.push_back(1);
    end
    for (int k = 0; k < 256; k++) begin
      if ((k / CPB) < q.size()) v[k] = q[k / CPB][0];
    end
    return v;
  endfunction

  function automatic logic [255:0] exp_done(input int idx, input int nfr);
    logic [255:0] v;
    v = '0;
    for (int f = 1; f <= nfr; f++) v[f * flen(idx) - 1] = 1'b1;
    return v;
  endfunction

  function automatic logic [255:0] exp_ready(input int idx, input int nfr);
    logic [255:0] v;
    v = '1;
    for (int k = 0; k < nfr * flen(idx); k++) v[k] = (((k + 1) % flen(idx)) == 0);
    return v;
  endfunction

  // mode 0: single send; 1: data/valid noise mid-frame; 2: valid held, d1 queued behind d0.
  task automatic run_frame(input int idx, input logic [8:0] d0, input logic [8:0] d1,
                           input int mode, input int ncyc,
                           output logic [255:0] ser, output logic [255:0] dn,
                           output logic [255:0] rd);
    int f;
    f   = flen(idx);
    ser = '1;
    dn  = '0;
    rd  = '1;
    @(negedge clk);
    n_tests++;
    if (rdy_w[idx] !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_before_send[%0d]: got %b want 1", idx, rdy_w[idx]);
    end
    tx_data_a[idx] = d0;
    valid_r[idx]   = 1'b1;
    @(posedge clk);
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (mode == 2) begin
        if (k == 0) tx_data_a[idx] = d1;
        if (k == f) valid_r[idx] = 1'b0;
      end else if (k == 0) begin
        valid_r[idx] = 1'b0;
      end
      if ((mode == 1) && (k > 0) && (k < f - 5)) begin
        tx_data_a[idx] = 9'($urandom);
        valid_r[idx]   = ($urandom_range(0, 3) == 0);
      end
      if ((mode == 1) && (k == f - 5)) valid_r[idx] = 1'b0;
      ser[k] = ser_w[idx];
      dn[k]  = done_w[idx];
      rd[k]  = rdy_w[idx];
    end
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    valid_r = '0;
    for (int i = 0; i < 4; i++) tx_data_a[i] = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({ser_w, rdy_w, busy_w, done_w} !== {4'hF, 4'hF, 4'h0, 4'h0}) begin
      n_fail++;
      $display("FAIL reset_in: got ser=%b rdy=%b busy=%b done=%b want 1111 1111 0000 0000",
               ser_w, rdy_w, busy_w, done_w);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({ser_w, rdy_w, busy_w, done_w} !== {4'hF, 4'hF, 4'h0, 4'h0}) begin
      n_fail++;
      $display("FAIL reset_out: got ser=%b rdy=%b busy=%b done=%b want 1111 1111 0000 0000",
               ser_w, rdy_w, busy_w, done_w);
    end
  endtask

  task automatic send_check(input int idx, input logic [8:0] d, input string nm);
    logic [255:0] ser, dn, rd;
    int           f;
    f = flen(idx);
    run_frame(idx, d, 9'h0, 0, f + 8, ser, dn, rd);
    n_tests++;
    if (ser !== exp_line(idx, d, 9'h0, 1)) begin
      n_fail++;
      $display("FAIL %s_line: got %h want %h", nm, ser, exp_line(idx, d, 9'h0, 1));
    end
    n_tests++;
    if (dn !== exp_done(idx, 1)) begin
      n_fail++;
      $display("FAIL %s_done: got %h want %h", nm, dn, exp_done(idx, 1));
    end
    n_tests++;
    if (rd !== exp_ready(idx, 1)) begin
      n_fail++;
      $display("FAIL %s_ready: got %h want %h", nm, rd, exp_ready(idx, 1));
    end
  endtask

  task automatic test_8n1();
    logic [255:0] ser, dn, rd;
    send_check(0, 9'h0AA, "8n1_aa");
    run_frame(0, 9'h0AA, 9'h0, 0, 110, ser, dn, rd);
    n_tests++;
    if ({ser[9:0], ser[19:10], ser[99:90], dn[99], dn[98]} !== {10'h000, 10'h000, 10'h3FF, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL 8n1_fixed: got start=%h d0=%h stop=%h done99=%b done98=%b want 000 000 3ff 1 0",
               ser[9:0], ser[19:10], ser[99:90], dn[99], dn[98]);
    end
  endtask

  task automatic test_parity();
    logic [255:0] ser, dn, rd;
    send_check(1, 9'h007, "8e1_07");
    send_check(2, 9'h007, "8o1_07");
    run_frame(1, 9'h007, 9'h0, 0, 115, ser, dn, rd);
    n_tests++;
    if ({ser[95], dn[109]} !== 2'b11) begin
      n_fail++;
      $display("FAIL 8e1_parity_bit: got par=%b done110=%b want 1 1", ser[95], dn[109]);
    end
    run_frame(2, 9'h007, 9'h0, 0, 115, ser, dn, rd);
    n_tests++;
    if ({ser[95], dn[109]} !== 2'b01) begin
      n_fail++;
      $display("FAIL 8o1_parity_bit: got par=%b done110=%b want 0 1", ser[95], dn[109]);
    end
  endtask

  task automatic test_7n2();
    logic [255:0] ser, dn, rd;
    send_check(3, 9'h041, "7n2_41");
    run_frame(3, 9'h041, 9'h0, 0, 110, ser, dn, rd);
    n_tests++;
    if ({ser[15], ser[25], ser[75], ser[85], ser[95], dn[99]} !== 6'b101111) begin
      n_fail++;
      $display("FAIL 7n2_fixed: got b0=%b b1=%b b6=%b s1=%b s2=%b done100=%b want 1 0 1 1 1 1",
               ser[15], ser[25], ser[75], ser[85], ser[95], dn[99]);
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] ser, dn, rd;
    run_frame(0, 9'h055, 9'h00F, 2, 215, ser, dn, rd);
    n_tests++;
    if (ser !== exp_line(0, 9'h055, 9'h00F, 2)) begin
      n_fail++;
      $display("FAIL b2b_line: got %h want %h", ser, exp_line(0, 9'h055, 9'h00F, 2));
    end
    n_tests++;
    if (dn !== exp_done(0, 2)) begin
      n_fail++;
      $display("FAIL b2b_done: got %h want %h", dn, exp_done(0, 2));
    end
    n_tests++;
    if (rd !== exp_ready(0, 2)) begin
      n_fail++;
      $display("FAIL b2b_ready: got %h want %h", rd, exp_ready(0, 2));
    end
    n_tests++;
    if ({ser[99], ser[100], ser[0], $countones(dn)} !== {1'b1, 1'b0, 1'b0, 32'd2}) begin
      n_fail++;
      $display("FAIL b2b_gap: got c100=%b c101=%b c1=%b dones=%0d want 1 0 0 2",
               ser[99], ser[100], ser[0], $countones(dn));
    end
  endtask

  task automatic test_reset_midframe();
    int dones;
    int highs;
    @(negedge clk);
    tx_data_a[0] = 9'h0AA;
    valid_r[0]   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_r[0] = 1'b0;
    repeat (34) @(negedge clk);
    n_tests++;
    if ({ser_w[0], rdy_w[0], busy_w[0]} !== 3'b001) begin
      n_fail++;
      $display("FAIL mid_before_rst: got ser=%b rdy=%b busy=%b want 0 0 1", ser_w[0], rdy_w[0], busy_w[0]);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({ser_w[0], rdy_w[0], busy_w[0], done_w[0]} !== 4'b1100) begin
      n_fail++;
      $display("FAIL mid_rst_async: got ser=%b rdy=%b busy=%b done=%b want 1 1 0 0",
               ser_w[0], rdy_w[0], busy_w[0], done_w[0]);
    end
    @(negedge clk);
    rst   = 1'b0;
    dones = 0;
    highs = 0;
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      dones += int'(done_w[0]);
      highs += int'(ser_w[0]);
    end
    n_tests++;
    if ((dones != 0) || (highs != 120)) begin
      n_fail++;
      $display("FAIL mid_rst_quiet: got dones=%0d high_cycles=%0d want 0 120", dones, highs);
    end
    send_check(0, 9'h03C, "after_rst_3c");
  endtask

  task automatic test_midframe_noise();
    logic [255:0] ser, dn, rd;
    logic [8:0]   d;
    for (int idx = 0; idx < 4; idx++) begin
      d = 9'($urandom);
      run_frame(idx, d, 9'h0, 1, flen(idx) + 30, ser, dn, rd);
      n_tests++;
      if ((ser !== exp_line(idx, d, 9'h0, 1)) || (dn !== exp_done(idx, 1))) begin
        n_fail++;
        $display("FAIL noise_frame[%0d]: got line=%h done=%h want line=%h done=%h",
                 idx, ser, dn, exp_line(idx, d, 9'h0, 1), exp_done(idx, 1));
      end
    end
  endtask

  task automatic test_random();
    logic [255:0] ser, dn, rd;
    logic [8:0]   d;
    for (int r = 0; r < 3; r++) begin
      for (int idx = 0; idx < 4; idx++) begin
        d = 9'($urandom);
        run_frame(idx, d, 9'h0, 0, flen(idx) + 6, ser, dn, rd);
        n_tests++;
        if (ser !== exp_line(idx, d, 9'h0, 1)) begin
          n_fail++;
          $display("FAIL rand_line[%0d] d=%h: got %h want %h", idx, d, ser, exp_line(idx, d, 9'h0, 1));
        end
        n_tests++;
        if ((dn !== exp_done(idx, 1)) || (rd !== exp_ready(idx, 1))) begin
          n_fail++;
          $display("FAIL rand_hs[%0d] d=%h: got done=%h rdy=%h want done=%h rdy=%h",
                   idx, d, dn, rd, exp_done(idx, 1), exp_ready(idx, 1));
        end
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_8n1();
    test_parity();
    test_7n2();
    test_back_to_back();
    test_reset_midframe();
    test_midframe_noise();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
